regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DW, default 32: register data width in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL have parameter AW, default 5: register address width; the block holds NREGS = 2**AW registers.
REQ-003 SHALL have parameter ZERO_REG, default 1: when 1, register 0 is hardwired to zero.
REQ-004 clk  in  1  single clock; all state updates on the posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 read1, read2  in  AW each  read-port addresses.
REQ-007 data1, data2  out  DW each  read data, combinational.
REQ-008 busy1, busy2  out  1 each  scoreboard pending bit of read1 and read2.
REQ-009 regwrite  in  1  writeback enable.
REQ-010 regtowrite  in  AW  writeback address.
REQ-011 datatowrite  in  DW  writeback data.
REQ-012 byteen  in  DW/8  per-byte write enable; bit i covers data bits [8i+7:8i].
REQ-013 issue  in  1  mark a destination register as pending.
REQ-014 issuereg  in  AW  destination address for issue.
REQ-015 stall  out  1  equals busy1 OR busy2.

Function
REQ-016 Storage SHALL be NREGS x DW.
- On a clk posedge with regwrite=1, each byte whose byteen bit is 1 SHALL take the matching byte of datatowrite.
- Bytes whose byteen bit is 0 SHALL keep their value.
REQ-017 With ZERO_REG=1, writes to address 0 SHALL be ignored, reads of address 0 SHALL return 0, and busy for address 0 SHALL always be 0.
REQ-018 Read ports SHALL be combinational, with zero latency.
REQ-019 Write-through bypass: when regwrite=1 and readN==regtowrite (and the address is nonzero under ZERO_REG=1), dataN SHALL present the merged value in the same cycle.
- Merged value = enabled bytes from datatowrite, other bytes from storage.
REQ-020 The scoreboard SHALL hold one busy bit per register.
- issue=1 SHALL set busy[issuereg] on the posedge.
- regwrite=1 SHALL clear busy[regtowrite] on the posedge, whatever the byteen value.
REQ-021 If issue and regwrite target the same register in the same cycle, set SHALL win: the bit ends at 1 and the data write still occurs.
REQ-022 Setting an already-busy bit SHALL keep it 1; clearing a non-busy bit SHALL keep it 0; no error is flagged.
REQ-023 busyN SHALL be the registered bit ANDed with NOT(regwrite AND regtowrite==readN), so a same-cycle writeback releases the stall combinationally.
REQ-024 Both read ports SHALL be fully independent; read1==read2 SHALL return identical data and busy values.
REQ-025 All addresses SHALL be in range by construction (power-of-two depth); no wrap logic is needed.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear all NREGS registers to 0 and all busy bits to 0.
- While in reset, data1/data2 SHALL read 0, and busy1/busy2/stall SHALL be 0.
REQ-027 A write or issue in the same cycle as reset assertion SHALL be discarded.
REQ-028 Deassertion SHALL take effect at the next posedge.
- The first posedge after rst_n rises SHALL accept writes and issues normally.
REQ-029 Reset asserted mid-operation, with pending busy bits, SHALL clear every busy bit; no pending state survives.

Verification
REQ-030 Reset, then read all addresses on both ports -> every data=0, every busy=0, stall=0.
REQ-031 Write 0xDEADBEEF to r5 with byteen=1111, then write 0x000000AA to r5 with byteen=0001 -> r5 reads 0xDEADBEAA; during the second write cycle data1 (read1=5) already shows 0xDEADBEAA.
REQ-032 With ZERO_REG=1, write 0xFFFFFFFF to r0 and issue r0 -> r0 reads 0, busy=0.
REQ-033 Issue r7; next cycle read1=7 -> busy1=1, stall=1; writeback r7=0x12345678 -> busy1=0 in that same cycle, data1=0x12345678; busy stays 0 after the posedge.
REQ-034 Issue r3 and writeback r3=0x55 in the same cycle -> r3 reads 0x55 and busy for r3=1 after the posedge.
REQ-035 Issue r9 and write r9=0x1, then assert rst_n=0 between clock edges -> r9 reads 0 and busy=0 immediately; run DW=16, AW=3 and DW=64, AW=6 builds through the same scenarios.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with byte-enabled writeback, write-through read bypass and a
// per-register pending (busy) scoreboard that drives a combinational stall.
module regfile_sb #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     read1,
    input  logic [AW-1:0]     read2,
    output logic [DW-1:0]     data1,
    output logic [DW-1:0]     data2,
    output logic              busy1,
    output logic              busy2,
    input  logic              regwrite,
    input  logic [AW-1:0]     regtowrite,
    input  logic [DW-1:0]     datatowrite,
    input  logic [DW/8-1:0]   byteen,
    input  logic              issue,
    input  logic [AW-1:0]     issuereg,
    output logic              stall
);

    localparam int NREGS = 2**AW;
    localparam int NB    = DW/8;

    logic [DW-1:0]    regs_q [NREGS];
    logic [DW-1:0]    regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wr_ok_s;
    logic [DW-1:0]    merged_s;
    logic             hit1_s;
    logic             hit2_s;

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_v,
                                                  input logic [DW-1:0] new_v,
                                                  input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                r[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                r[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return r;
    endfunction

    // Writeback qualification and the merged word shared by storage and bypass.
    always_comb begin
        wr_ok_s  = regwrite && !((ZERO_REG == 1) && (regtowrite == {AW{1'b0}}));
        merged_s = merge_bytes(regs_q[regtowrite], datatowrite, byteen);
    end

    // Next-state storage and scoreboard; set wins over clear on the same register.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            if (wr_ok_s && (regtowrite == i[AW-1:0])) begin
                regs_d[i] = merged_s;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
        busy_d = busy_q;
        if (regwrite) begin
            busy_d[regtowrite] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (issue) begin
            busy_d[issuereg] = 1'b1;
        end else begin
            busy_d[issuereg] = busy_d[issuereg];
        end
        if (ZERO_REG == 1) begin
            busy_d[0] = 1'b0;
        end else begin
            busy_d[0] = busy_d[0];
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DW{1'b0}};
            end
            busy_q <= {NREGS{1'b0}};
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Read ports: bypass on address match, forced to zero in reset and for r0.
    always_comb begin
        hit1_s = wr_ok_s && (regtowrite == read1);
        hit2_s = wr_ok_s && (regtowrite == read2);
        if (!rst_n || ((ZERO_REG == 1) && (read1 == {AW{1'b0}}))) begin
            data1 = {DW{1'b0}};
        end else if (hit1_s) begin
            data1 = merged_s;
        end else begin
            data1 = regs_q[read1];
        end
        if (!rst_n || ((ZERO_REG == 1) && (read2 == {AW{1'b0}}))) begin
            data2 = {DW{1'b0}};
        end else if (hit2_s) begin
            data2 = merged_s;
        end else begin
            data2 = regs_q[read2];
        end
        busy1 = rst_n && busy_q[read1] && !(regwrite && (regtowrite == read1));
        busy2 = rst_n && busy_q[read2] && !(regwrite && (regtowrite == read2));
        stall = busy1 || busy2;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised and directed bench for regfile_sb against an array-based model.
module tb_regfile_sb;

    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int ZERO_REG = 1;
    localparam int NREGS    = 1 << AW;
    localparam int NB       = DW / 8;

    localparam logic [AW-1:0] R3 = AW'(3 % NREGS);
    localparam logic [AW-1:0] R5 = AW'(5 % NREGS);
    localparam logic [AW-1:0] R7 = AW'(7 % NREGS);
    localparam logic [AW-1:0] R9 = AW'(9 % NREGS);

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   read1, read2, regtowrite, issuereg;
    logic [DW-1:0]   data1, data2, datatowrite;
    logic            busy1, busy2, stall, regwrite, issue;
    logic [NB-1:0]   byteen;

    logic [DW-1:0]   mdl_regs [NREGS];
    bit              mdl_busy [NREGS];
    int              n_pass;
    int              n_total;

    regfile_sb #(.DW(DW), .AW(AW), .ZERO_REG(ZERO_REG)) dut (
        .clk(clk), .rst_n(rst_n), .read1(read1), .read2(read2),
        .data1(data1), .data2(data2), .busy1(busy1), .busy2(busy2),
        .regwrite(regwrite), .regtowrite(regtowrite), .datatowrite(datatowrite),
        .byteen(byteen), .issue(issue), .issuereg(issuereg), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] byte_mask(input logic [NB-1:0] be);
        logic [DW-1:0] m;
        m = '0;
        for (int b = 0; b < NB; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic bit is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG == 1) && (a == '0);
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        logic [DW-1:0] m;
        m = byte_mask(byteen);
        if (!rst_n || is_zero_reg(a)) return '0;
        if (regwrite && regtowrite == a) return (mdl_regs[a] & ~m) | (datatowrite & m);
        return mdl_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (!rst_n) return 1'b0;
        return mdl_busy[a] && !(regwrite && regtowrite == a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            mdl_regs[i] = '0;
            mdl_busy[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        logic [DW-1:0] m;
        m = byte_mask(byteen);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (regwrite && !is_zero_reg(regtowrite))
                mdl_regs[regtowrite] = (mdl_regs[regtowrite] & ~m) | (datatowrite & m);
            if (regwrite) mdl_busy[regtowrite] = 1'b0;
            if (issue && !is_zero_reg(issuereg)) mdl_busy[issuereg] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        regwrite = 1'b0;
        issue    = 1'b0;
        byteen   = '1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #1;
        model_reset();
        for (int a = 0; a < NREGS; a++) begin
            read1 = AW'(a);
            read2 = AW'(NREGS - 1 - a);
            #1;
            n_total++;
            if (data1 !== '0 || data2 !== '0) $display("FAIL reset_data a=%0d: got %h/%h expected 0", a, data1, data2);
            else n_pass++;
            n_total++;
            if ({busy1, busy2, stall} !== 3'b000) $display("FAIL reset_busy a=%0d: got %b expected 000", a, {busy1, busy2, stall});
            else n_pass++;
        end
        // write and issue held across a posedge while in reset must vanish
        regwrite = 1'b1; regtowrite = R5; datatowrite = '1; issue = 1'b1; issuereg = R5;
        read1 = R5;
        #1;
        n_total++;
        if (data1 !== '0) $display("FAIL reset_bypass: got %h expected 0", data1);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        n_total++;
        if (data1 !== '0 || busy1 !== 1'b0) $display("FAIL reset_discard: got %h/%b expected 0/0", data1, busy1);
        else n_pass++;
        tick();
    endtask

    task automatic test_byte_merge();
        logic [DW-1:0] v1, expv;
        v1 = DW'(64'hDEADBEEF);
        expv = v1;
        expv[7:0] = 8'hAA;
        regwrite = 1'b1; regtowrite = R5; datatowrite = v1; byteen = '1;
        read1 = R5; read2 = R5;
        tick();
        datatowrite = DW'(32'h000000AA);
        byteen = NB'(1);
        #1;
        n_total++;
        if (data1 !== expv) $display("FAIL merge_bypass: got %h expected %h", data1, expv);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (data1 !== expv || data2 !== expv) $display("FAIL merge_stored: got %h/%h expected %h", data1, data2, expv);
        else n_pass++;
    endtask

    task automatic test_zero_reg();
        regwrite = 1'b1; regtowrite = '0; datatowrite = '1; byteen = '1;
        issue = 1'b1; issuereg = '0; read1 = '0; read2 = '0;
        #1;
        n_total++;
        if (data1 !== exp_data('0) || busy1 !== exp_busy('0)) $display("FAIL zero_same: got %h/%b expected %h/%b", data1, busy1, exp_data('0), exp_busy('0));
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (data1 !== exp_data('0) || busy1 !== exp_busy('0) || stall !== exp_busy('0)) $display("FAIL zero_after: got %h/%b expected %h/%b", data1, busy1, exp_data('0), exp_busy('0));
        else n_pass++;
    endtask

    task automatic test_issue_writeback();
        logic [DW-1:0] v;
        v = DW'(32'h12345678);
        issue = 1'b1; issuereg = R7;
        tick();
        idle();
        read1 = R7; read2 = R5;
        #1;
        n_total++;
        if (busy1 !== 1'b1 || stall !== 1'b1) $display("FAIL issue_busy: got %b/%b expected 1/1", busy1, stall);
        else n_pass++;
        regwrite = 1'b1; regtowrite = R7; datatowrite = v; byteen = '1;
        #1;
        n_total++;
        if (busy1 !== 1'b0 || stall !== 1'b0 || data1 !== v) $display("FAIL wb_release: got %b/%b/%h expected 0/0/%h", busy1, stall, data1, v);
        else n_pass++;
        tick();
        idle();
        #1;
        n_total++;
        if (busy1 !== 1'b0 || data1 !== v) $display("FAIL wb_after: got %b/%h expected 0/%h", busy1, data1, v);
        else n_pass++;
    endtask

    task automatic test_set_wins();
        logic [DW-1:0] v;
        v = DW'(32'h55);
        issue = 1'b1; issuereg = R3;
        regwrite = 1'b1; regtowrite = R3; datatowrite = v; byteen = '1;
        tick();
        idle();
        read1 = R3; read2 = R3;
        #1;
        n_total++;
        if (data1 !== v || busy1 !== 1'b1 || busy2 !== 1'b1) $display("FAIL set_wins: got %h/%b/%b expected %h/1/1", data1, busy1, busy2, v);
        else n_pass++;
        // a writeback with no bytes enabled still clears the pending bit
        regwrite = 1'b1; regtowrite = R3; datatowrite = '1; byteen = '0;
        tick();
        idle();
        #1;
        n_total++;
        if (data1 !== v || busy1 !== 1'b0) $display("FAIL clear_no_bytes: got %h/%b expected %h/0", data1, busy1, v);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            regwrite    = ($urandom_range(0, 1) == 1);
            issue       = ($urandom_range(0, 2) == 0);
            regtowrite  = AW'($urandom_range(0, NREGS - 1));
            issuereg    = AW'($urandom_range(0, NREGS - 1));
            datatowrite = DW'({$urandom, $urandom});
            byteen      = NB'($urandom);
            case ($urandom_range(0, 3))
                0: read1 = regtowrite;
                1: read1 = issuereg;
                default: read1 = AW'($urandom_range(0, NREGS - 1));
            endcase
            case ($urandom_range(0, 3))
                0: read2 = read1;
                1: read2 = regtowrite;
                default: read2 = AW'($urandom_range(0, NREGS - 1));
            endcase
            #1;
            n_total++;
            if (data1 !== exp_data(read1) || data2 !== exp_data(read2))
                $display("FAIL rand_data c=%0d: got %h/%h expected %h/%h", c, data1, data2, exp_data(read1), exp_data(read2));
            else n_pass++;
            n_total++;
            if (busy1 !== exp_busy(read1) || busy2 !== exp_busy(read2) || stall !== (exp_busy(read1) | exp_busy(read2)))
                $display("FAIL rand_busy c=%0d: got %b%b%b expected %b%b", c, busy1, busy2, stall, exp_busy(read1), exp_busy(read2));
            else n_pass++;
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid();
        issue = 1'b1; issuereg = R9;
        regwrite = 1'b1; regtowrite = R9; datatowrite = DW'(1); byteen = '1;
        tick();
        idle();
        read1 = R9; read2 = R9;
        #1;
        n_total++;
        if (data1 !== DW'(1) || busy1 !== 1'b1) $display("FAIL mid_pre: got %h/%b expected 1/1", data1, busy1);
        else n_pass++;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (data1 !== '0 || busy1 !== 1'b0 || busy2 !== 1'b0 || stall !== 1'b0) $display("FAIL mid_reset: got %h/%b/%b expected 0/0/0", data1, busy1, stall);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        regwrite = 1'b1; regtowrite = R9; datatowrite = DW'(2); byteen = '1;
        issue = 1'b1; issuereg = R9;
        tick();
        idle();
        #1;
        n_total++;
        if (data1 !== DW'(2) || busy1 !== 1'b1) $display("FAIL first_edge: got %h/%b expected 2/1", data1, busy1);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        read1 = '0; read2 = '0; regtowrite = '0; issuereg = '0;
        datatowrite = '0;
        test_reset();
        test_byte_merge();
        test_zero_reg();
        test_issue_writeback();
        test_set_wins();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
